ppu_ram_port: RTL

- Pin-level read port between the PPU's internal memory fetch logic and the narrow external RAM interface (address-out / data-in nibble pins).
- Accepts one read request per transaction through a valid/ready handshake.
- Serializes each request as a framed address on the address pins and deserializes the fixed-latency reply from the data pins.
- Returns the full word as a one-cycle response pulse. Address frames may overlap with reply reception of the previous request.

---
 rtl/ppu_ram_port.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ppu_ram_port.sv
// ppu_ram_port: read port from the PPU fetch logic to a narrow external RAM.
// A request is framed on addr_pins as a start code (all ones) followed by the
// address nibbles, MSB first. The reply comes back on data_pins a fixed number
// of cycles after the last address nibble and is returned as one word.
module ppu_ram_port #(
  parameter int RAM_PINS     = 4,
  parameter int ADDR_BITS    = 16,
  parameter int DATA_BITS    = 16,
  parameter int READ_LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_BITS-1:0] req_addr,
  output logic                 rsp_valid,
  output logic [DATA_BITS-1:0] rsp_data,
  output logic [RAM_PINS-1:0]  addr_pins,
  input  logic [RAM_PINS-1:0]  data_pins
);

  localparam int NA = ADDR_BITS / RAM_PINS;
  localparam int ND = DATA_BITS / RAM_PINS;
  localparam int KW = (NA > 1) ? $clog2(NA) : 1;
  localparam int DW = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NA - 1);
  localparam logic [DW-1:0] J_LAST = DW'(ND - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_ADDR
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [KW-1:0]         nib_idx;
  logic [KW-1:0]         nib_idx_nxt;
  logic [ADDR_BITS-1:0]  addr_sh;
  logic [ADDR_BITS-1:0]  addr_sh_nxt;
  logic [RAM_PINS-1:0]   pins_nxt;
  logic                  last_nib;
  logic                  accept;

  logic [READ_LATENCY-1:0] delay_line;
  logic                    cap_take;
  logic                    cap_busy;
  logic [DW-1:0]           cap_idx;
  logic [DATA_BITS-1:0]    shadow;
  logic [DATA_BITS-1:0]    shadow_nxt;

  // The final address nibble cycle doubles as an accept slot so frames can
  // run back to back; it is also the cycle that launches the reply token.
  assign last_nib  = (state == S_ADDR) && (nib_idx == K_LAST);
  assign req_ready = rst_n && ((state == S_IDLE) || last_nib);
  assign accept    = req_valid && req_ready;

  // Serializer next state; addr_pins is registered, so its next value is
  // computed here from the state being entered.
  always_comb begin
    state_nxt   = state;
    nib_idx_nxt = nib_idx;
    addr_sh_nxt = addr_sh;
    pins_nxt    = '0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt   = S_START;
          addr_sh_nxt = req_addr;
          pins_nxt    = '1;
        end
      end
      S_START: begin
        state_nxt   = S_ADDR;
        nib_idx_nxt = '0;
        pins_nxt    = addr_sh[ADDR_BITS-1 -: RAM_PINS];
        addr_sh_nxt = addr_sh << RAM_PINS;
      end
      S_ADDR: begin
        if (nib_idx == K_LAST) begin
          if (accept) begin
            state_nxt   = S_START;
            addr_sh_nxt = req_addr;
            pins_nxt    = '1;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          nib_idx_nxt = nib_idx + 1'b1;
          pins_nxt    = addr_sh[ADDR_BITS-1 -: RAM_PINS];
          addr_sh_nxt = addr_sh << RAM_PINS;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Serializer state and the registered address pins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      nib_idx   <= '0;
      addr_sh   <= '0;
      addr_pins <= '0;
    end else begin
      state     <= state_nxt;
      nib_idx   <= nib_idx_nxt;
      addr_sh   <= addr_sh_nxt;
      addr_pins <= pins_nxt;
    end
  end

  // Token delay line: the top stage marks the cycle of the first data nibble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      delay_line <= '0;
    end else begin
      delay_line <= (delay_line << 1) | READ_LATENCY'(last_nib);
    end
  end

  // Frames are at least NA+1 cycles apart and ND <= NA+1, so a new token can
  // never arrive while the previous reply is still being shifted in.
  assign cap_take   = delay_line[READ_LATENCY-1] || cap_busy;
  assign shadow_nxt = (shadow << RAM_PINS) | DATA_BITS'(data_pins);

  // Deserializer: shift in ND nibbles, then publish the word with a pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_busy  <= 1'b0;
      cap_idx   <= '0;
      shadow    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (cap_take) begin
        shadow <= shadow_nxt;
        if (cap_idx == J_LAST) begin
          cap_busy  <= 1'b0;
          cap_idx   <= '0;
          rsp_valid <= 1'b1;
          rsp_data  <= shadow_nxt;
        end else begin
          cap_busy <= 1'b1;
          cap_idx  <= cap_idx + 1'b1;
        end
      end
    end
  end

endmodule
